// File: rtl/fmul_pkg.sv
// ---------------------------------------------------------------------------
// fmul_pkg
// Shared definitions for the iterative multiplier.
//   MODE_*  : encodings of the i_mode operand-signedness selector
//   state_t : control FSM states
// ---------------------------------------------------------------------------
package fmul_pkg;

    // Operand signedness selector. The fourth code (2'b11) carries no name of
    // its own: it is decoded exactly like MODE_UU.
    localparam logic [1:0] MODE_UU = 2'b00;
    localparam logic [1:0] MODE_SS = 2'b01;
    localparam logic [1:0] MODE_SU = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/fmul_sign_mag.sv
// ---------------------------------------------------------------------------
// fmul_sign_mag
// Conditional two's-complement negate. Used as abs() on operand capture and
// as the final sign fix-up of the product.
//   i_val [WIDTH-1:0] : value in
//   i_neg             : 1 = return -i_val (mod 2^WIDTH), 0 = pass through
//   o_val [WIDTH-1:0] : result
// ---------------------------------------------------------------------------
module fmul_sign_mag #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    // Taking -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is exactly the
    // unsigned magnitude wanted when this is used as abs().
    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/fmul_iter.sv
// ---------------------------------------------------------------------------
// fmul_iter
// Iterative shift-add multiplier, one partial product per clock.
// IDLE -> RUN (W cycles) -> FIN -> IDLE; results appear W+2 cycles after the
// edge that accepts i_start.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : request, sampled only in IDLE
//   i_mode [1:0]   : 00 uxu, 01 sxs, 10 s(rd)xu(rr), 11 as 00
//   i_frac         : 1 = result shifted left by one
//   i_rd, i_rr     : multiplicand, multiplier
//   o_busy         : operation in progress (RUN or FIN)
//   o_done         : one-cycle pulse, results valid
//   o_r1, o_r0     : result high / low halves
//   o_c, o_z       : product MSB (before frac shift), result-is-zero
// ---------------------------------------------------------------------------
module fmul_iter
    import fmul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [1:0]   i_mode,
    input  logic         i_frac,
    input  logic [W-1:0] i_rd,
    input  logic [W-1:0] i_rr,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_r1,
    output logic [W-1:0] o_r0,
    output logic         o_c,
    output logic         o_z
);

    localparam int CW = $clog2(W) + 1;

    state_t             state_q, state_d;
    logic [2*W-1:0]     acc_q, acc_d;
    logic [W-1:0]       mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic               frac_q, frac_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W-1:0]       r1_q, r1_d, r0_q, r0_d;
    logic               c_q, c_d, z_q, z_d, done_q, done_d;

    logic               neg_rd, neg_rr;
    logic [W-1:0]       mag_rd, mag_rr;
    logic [W:0]         sum;
    logic [2*W-1:0]     prod, res;

    // An operand is negative only when its mode treats it as signed and its
    // MSB is set; mode 11 falls into the unsigned case.
    assign neg_rd = ((i_mode == MODE_SS) || (i_mode == MODE_SU)) && i_rd[W-1];
    assign neg_rr = (i_mode == MODE_SS) && i_rr[W-1];

    fmul_sign_mag #(.WIDTH(W)) u_abs_rd (
        .i_val (i_rd),
        .i_neg (neg_rd),
        .o_val (mag_rd)
    );

    fmul_sign_mag #(.WIDTH(W)) u_abs_rr (
        .i_val (i_rr),
        .i_neg (neg_rr),
        .o_val (mag_rr)
    );

    fmul_sign_mag #(.WIDTH(2*W)) u_fix_sign (
        .i_val (acc_q),
        .i_neg (neg_q),
        .o_val (prod)
    );

    // Upper half accumulates the multiplicand when the current multiplier bit
    // (acc LSB) is set; the extra carry bit is shifted back in on the right.
    assign sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign res = frac_q ? {prod[2*W-2:0], 1'b0} : prod;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CW'(W - 1)) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy = (state_q == ST_RUN) || (state_q == ST_FIN);
    end

    // Datapath next-state: capture in IDLE, iterate in RUN, publish in FIN
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        frac_d  = frac_q;
        cnt_d   = cnt_q;
        r1_d    = r1_q;
        r0_d    = r0_q;
        c_d     = c_q;
        z_d     = z_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    mcand_d = mag_rd;
                    acc_d   = {{W{1'b0}}, mag_rr};
                    neg_d   = neg_rd ^ neg_rr;
                    frac_d  = i_frac;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                acc_d = {sum, acc_q[W-1:1]};
                cnt_d = cnt_q + CW'(1);
            end
            ST_FIN: begin
                r1_d   = res[2*W-1:W];
                r0_d   = res[W-1:0];
                c_d    = prod[2*W-1];
                z_d    = (res == '0);
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            frac_q  <= 1'b0;
            cnt_q   <= '0;
            r1_q    <= '0;
            r0_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            frac_q  <= frac_d;
            cnt_q   <= cnt_d;
            r1_q    <= r1_d;
            r0_q    <= r0_d;
            c_q     <= c_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign o_done = done_q;
    assign o_r1   = r1_q;
    assign o_r0   = r0_q;
    assign o_c    = c_q;
    assign o_z    = z_q;

endmodule

// File: tb/tb_fmul_iter.sv
// ---------------------------------------------------------------------------
// tb_fmul_iter
// Directed and randomized checks of fmul_iter (W=8) against an arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_fmul_iter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstN;
    logic         iStart;
    logic [1:0]   iMode;
    logic         iFrac;
    logic [W-1:0] iRd, iRr;
    logic         oBusy, oDone, oC, oZ;
    logic [W-1:0] oR1, oR0;

    int vectorCount = 0;
    int missCount   = 0;

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    fmul_iter #(.W(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_start (iStart),
        .i_mode  (iMode),
        .i_frac  (iFrac),
        .i_rd    (iRd),
        .i_rr    (iRr),
        .o_busy  (oBusy),
        .o_done  (oDone),
        .o_r1    (oR1),
        .o_r0    (oR0),
        .o_c     (oC),
        .o_z     (oZ)
    );

    // Reference: plain integer product, then wrap/shift. Returns {c, z, R}.
    function automatic logic [17:0] refModel(input logic [1:0] mode, input logic frac,
                                             input logic [7:0] rd, input logic [7:0] rr);
        longint a, b, p;
        logic [15:0] pw, rw;
        a  = (mode == 2'b01 || mode == 2'b10) ? longint'($signed(rd)) : longint'(rd);
        b  = (mode == 2'b01) ? longint'($signed(rr)) : longint'(rr);
        p  = a * b;
        pw = p[15:0];
        rw = frac ? {pw[14:0], 1'b0} : pw;
        return {pw[15], (rw == 16'h0000), rw};
    endfunction

    // One comparison: count it, and on mismatch count and report it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Launch one operation, scramble the inputs after capture, and wait
    // (bounded) for done. lat is the cycle index holding done, counting the
    // cycle right after the start edge as 1.
    task automatic applyStimulus(input logic [1:0] mode, input logic frac,
                                 input logic [7:0] rd, input logic [7:0] rr,
                                 output int lat, output int busyCycles,
                                 output logic busyAtDone, output logic doneAfter,
                                 output logic [7:0] r1, output logic [7:0] r0,
                                 output logic c, output logic z);
        @(negedge clk);
        iMode = mode; iFrac = frac; iRd = rd; iRr = rr; iStart = 1'b1;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        iRd = 8'($urandom); iRr = 8'($urandom);
        iMode = 2'($urandom); iFrac = 1'($urandom);
        lat = -1;
        busyCycles = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (oDone) begin
                lat = k;
                break;
            end
            if (oBusy) busyCycles++;
        end
        busyAtDone = oBusy;
        r1 = oR1; r0 = oR0; c = oC; z = oZ;
        @(negedge clk);
        doneAfter = oDone;
    endtask

    // Run one operation and compare everything against the model
    task automatic runAndCheck(input string tag, input logic [1:0] mode, input logic frac,
                               input logic [7:0] rd, input logic [7:0] rr,
                               output logic [7:0] r1, output logic [7:0] r0,
                               output logic c, output logic z);
        logic [17:0] exp;
        int lat, busyCycles;
        logic busyAtDone, doneAfter;
        exp = refModel(mode, frac, rd, rr);
        applyStimulus(mode, frac, rd, rr, lat, busyCycles, busyAtDone, doneAfter, r1, r0, c, z);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(W + 2));
        checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'(W + 1));
        checkOutput({tag, ".busyAtDone"}, 32'(busyAtDone), 32'd0);
        checkOutput({tag, ".donePulse"}, 32'(doneAfter), 32'd0);
        checkOutput({tag, ".r1"}, 32'(r1), 32'(exp[15:8]));
        checkOutput({tag, ".r0"}, 32'(r0), 32'(exp[7:0]));
        checkOutput({tag, ".c"}, 32'(c), 32'(exp[17]));
        checkOutput({tag, ".z"}, 32'(z), 32'(exp[16]));
    endtask

    // Main directed sequence followed by random operations
    initial begin
        logic [7:0]  r1, r0, r1A, r0A, r1B, r0B;
        logic        c, z;
        logic [17:0] expA, expB;
        logic [1:0]  mA, mB, rm;
        logic        fA, fB, rf;
        logic [7:0]  dA, qA, dB, qB, rd, rr;
        int          pulses, firstK, secondK;
        logic        doneSeen;

        rstN = 1'b0; iStart = 1'b0; iMode = 2'b00; iFrac = 1'b0; iRd = '0; iRr = '0;
        $display("[TB] reset phase");
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", 32'(oBusy), 32'd0);
        checkOutput("reset.done", 32'(oDone), 32'd0);
        checkOutput("reset.r1", 32'(oR1), 32'd0);
        checkOutput("reset.r0", 32'(oR0), 32'd0);
        checkOutput("reset.c", 32'(oC), 32'd0);
        checkOutput("reset.z", 32'(oZ), 32'd0);
        rstN = 1'b1;

        $display("[TB] directed operations");
        runAndCheck("zero", 2'b00, 1'b0, 8'h00, 8'h55, r1, r0, c, z);
        checkOutput("zero.const", {22'd0, r1, r0, c, z}, {22'd0, 8'h00, 8'h00, 1'b0, 1'b1});
        runAndCheck("uu_ff", 2'b00, 1'b0, 8'hFF, 8'hFF, r1, r0, c, z);
        checkOutput("uu_ff.const", {22'd0, r1, r0, c, z}, {22'd0, 8'hFE, 8'h01, 1'b1, 1'b0});
        runAndCheck("ss_min_frac", 2'b01, 1'b1, 8'h80, 8'h80, r1, r0, c, z);
        checkOutput("ss_min_frac.const", {22'd0, r1, r0, c, z}, {22'd0, 8'h80, 8'h00, 1'b0, 1'b0});
        runAndCheck("su_ff", 2'b10, 1'b0, 8'hFF, 8'hFF, r1, r0, c, z);
        checkOutput("su_ff.const", {23'd0, r1, r0, c}, {23'd0, 8'hFF, 8'h01, 1'b1});
        runAndCheck("su_frac", 2'b10, 1'b1, 8'hC0, 8'h40, r1, r0, c, z);
        checkOutput("su_frac.const", {23'd0, r1, r0, c}, {23'd0, 8'hE0, 8'h00, 1'b1});

        // Abort in RUN cycle 4; outputs hold nonzero values from su_frac here
        $display("[TB] reset during RUN");
        @(negedge clk);
        iMode = 2'b00; iFrac = 1'b0; iRd = 8'h12; iRr = 8'h34; iStart = 1'b1;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort.busyBefore", 32'(oBusy), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("abort.busy", 32'(oBusy), 32'd0);
        checkOutput("abort.done", 32'(oDone), 32'd0);
        checkOutput("abort.r1", 32'(oR1), 32'd0);
        checkOutput("abort.r0", 32'(oR0), 32'd0);
        checkOutput("abort.c", 32'(oC), 32'd0);
        checkOutput("abort.z", 32'(oZ), 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        doneSeen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (oDone) doneSeen = 1'b1;
        end
        checkOutput("abort.noDone", 32'(doneSeen), 32'd0);
        checkOutput("abort.idle", 32'(oBusy), 32'd0);
        runAndCheck("after_abort", 2'b01, 1'b0, 8'h9C, 8'h27, r1, r0, c, z);

        // Start held high through busy; second operand set applied in the done cycle
        $display("[TB] back-to-back");
        mA = 2'b01; fA = 1'b0; dA = 8'hF3; qA = 8'h2B;
        mB = 2'b10; fB = 1'b1; dB = 8'h85; qB = 8'hC7;
        expA = refModel(mA, fA, dA, qA);
        expB = refModel(mB, fB, dB, qB);
        r1A = '0; r0A = '0; r1B = '0; r0B = '0;
        @(negedge clk);
        iMode = mA; iFrac = fA; iRd = dA; iRr = qA; iStart = 1'b1;
        @(posedge clk);
        #1;
        iRd = 8'($urandom); iRr = 8'($urandom); iMode = 2'($urandom); iFrac = 1'($urandom);
        pulses = 0; firstK = -1; secondK = -1;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (oDone) begin
                pulses++;
                if (pulses == 1) begin
                    firstK = k; r1A = oR1; r0A = oR0;
                    iMode = mB; iFrac = fB; iRd = dB; iRr = qB;
                end else if (pulses == 2) begin
                    secondK = k; r1B = oR1; r0B = oR0;
                end
            end
            if (firstK > 0 && k == firstK + 1) iStart = 1'b0;
        end
        iStart = 1'b0;
        checkOutput("b2b.pulses", 32'(pulses), 32'd2);
        checkOutput("b2b.first", 32'(firstK), 32'(W + 2));
        checkOutput("b2b.spacing", 32'(secondK - firstK), 32'(W + 2));
        checkOutput("b2b.resA", {16'd0, r1A, r0A}, {16'd0, expA[15:0]});
        checkOutput("b2b.resB", {16'd0, r1B, r0B}, {16'd0, expB[15:0]});

        $display("[TB] random operations");
        for (int n = 0; n < 20; n++) begin
            rm = 2'($urandom); rf = 1'($urandom);
            rd = 8'($urandom); rr = 8'($urandom);
            runAndCheck($sformatf("rand%0d", n), rm, rf, rd, rr, r1, r0, c, z);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
